// File: rtl/sqvl_seq_ctrl.sv
// Square-wave voltage sequencer: alternates a high/low level with programmable durations
// and issues the downstream load strobe when each new level reaches the path register.
module sqvl_seq_ctrl #(
  parameter int unsigned DW       = 12,
  parameter int unsigned CW       = 16,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          cfg_load,
  input  logic [DW-1:0] v_high,
  input  logic [DW-1:0] v_low,
  input  logic [CW-1:0] t_high,
  input  logic [CW-1:0] t_low,
  output logic [DW-1:0] v_out,
  output logic          en,
  output logic          busy,
  output logic          phase,
  output logic          period_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] vh_stg, vl_stg, vh_act, vl_act;
  logic [CW-1:0] th_stg, tl_stg, th_act, tl_act;
  logic          pending;
  logic          stop_req;
  logic          chg;
  logic          inflight;
  logic          apply;
  logic [DW-1:0] vh_eff;
  logic [CW-1:0] th_eff;

  function automatic logic [CW-1:0] reload(input logic [CW-1:0] t);
    return (t == '0) ? '0 : t - CW'(1);
  endfunction

  // A pending copy lands in IDLE or at the LOW->HIGH boundary of a continuing run;
  // a HIGH reload on that same edge must already see the new values.
  always_comb begin
    apply  = pending && ((state == S_IDLE) ||
                         (state == S_LOW && cnt == '0 && !stop_req));
    vh_eff = pending ? vh_stg : vh_act;
    th_eff = pending ? th_stg : th_act;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      v_out       <= '0;
      phase       <= 1'b0;
      period_done <= 1'b0;
      chg         <= 1'b0;
      stop_req    <= 1'b0;
      pending     <= 1'b0;
      vh_stg      <= '0;
      vl_stg      <= '0;
      th_stg      <= '0;
      tl_stg      <= '0;
      vh_act      <= '0;
      vl_act      <= '0;
      th_act      <= '0;
      tl_act      <= '0;
    end else begin
      chg         <= 1'b0;
      period_done <= 1'b0;

      if (cfg_load) begin
        vh_stg <= v_high;
        vl_stg <= v_low;
        th_stg <= t_high;
        tl_stg <= t_low;
      end
      pending <= cfg_load | (pending & ~apply);
      if (apply) begin
        vh_act <= vh_stg;
        vl_act <= vl_stg;
        th_act <= th_stg;
        tl_act <= tl_stg;
      end

      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            state <= S_HIGH;
            phase <= 1'b1;
            v_out <= vh_eff;
            cnt   <= reload(th_eff);
            chg   <= 1'b1;
          end
        end
        S_HIGH: begin
          if (stop) stop_req <= 1'b1;
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state       <= S_LOW;
            phase       <= 1'b0;
            v_out       <= vl_act;
            cnt         <= reload(tl_act);
            chg         <= 1'b1;
            period_done <= (tl_act <= CW'(1));
          end
        end
        S_LOW: begin
          if (stop) stop_req <= 1'b1;
          if (cnt != '0) begin
            cnt         <= cnt - CW'(1);
            period_done <= (cnt == CW'(1));
          end else if (stop_req) begin
            state    <= S_IDLE;
            stop_req <= 1'b0;
          end else begin
            state <= S_HIGH;
            phase <= 1'b1;
            v_out <= vh_eff;
            cnt   <= reload(th_eff);
            chg   <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          phase <= 1'b0;
        end
      endcase
    end
  end

  generate
    if (PIPE_LAT == 0) begin : g_no_delay
      assign en       = chg;
      assign inflight = 1'b0;
    end else begin : g_delay
      logic [PIPE_LAT-1:0] dl;
      always_ff @(posedge clk) begin
        if (reset) dl <= '0;
        else       dl <= (dl << 1) | PIPE_LAT'(chg);
      end
      assign en       = dl[PIPE_LAT-1];
      assign inflight = |dl;
    end
  endgenerate

  assign busy = (state != S_IDLE) | inflight;

endmodule

// File: tb/tb_sqvl_seq_ctrl.sv
// Bench for sqvl_seq_ctrl: phase-level behavioural model checked every cycle, plus
// hand-computed literal expectations for the documented scenarios.
module tb_sqvl_seq_ctrl;
  localparam int unsigned PL = 2;

  logic        clk;
  logic        reset, start, stop, cfg_load;
  logic [11:0] v_high, v_low;
  logic [15:0] t_high, t_low;
  logic [11:0] v_out;
  logic        en, busy, phase, period_done;

  sqvl_seq_ctrl #(.DW(12), .CW(16), .PIPE_LAT(PL)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .cfg_load(cfg_load),
    .v_high(v_high), .v_low(v_low), .t_high(t_high), .t_low(t_low),
    .v_out(v_out), .en(en), .busy(busy), .phase(phase), .period_done(period_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: mode 0=idle 1=high 2=low, m_rem = cycles left in the current phase,
  // enq = absolute cycle numbers at which a load strobe must appear.
  bit          model_ok = 0;
  int          m_mode;
  int unsigned m_rem;
  logic [11:0] m_vout;
  logic [11:0] s_vh, s_vl, a_vh, a_vl;
  int unsigned s_th, s_tl, a_th, a_tl;
  bit          m_pend, m_stopq, newlvl, halt;
  int unsigned enq[$];

  function automatic int unsigned dur(input int unsigned t);
    return (t == 0) ? 1 : t;
  endfunction

  always @(posedge clk) begin
    cyc++;
    while (enq.size() > 0 && enq[0] < cyc) void'(enq.pop_front());
    if (reset) begin
      model_ok = 1;
      m_mode = 0; m_rem = 0; m_vout = '0;
      s_vh = '0; s_vl = '0; a_vh = '0; a_vl = '0;
      s_th = 0; s_tl = 0; a_th = 0; a_tl = 0;
      m_pend = 0; m_stopq = 0;
      enq.delete();
    end else begin
      newlvl = 0;
      case (m_mode)
        0: begin
          if (m_pend) begin
            a_vh = s_vh; a_vl = s_vl; a_th = s_th; a_tl = s_tl; m_pend = 0;
          end
          if (start && !stop) begin
            m_mode = 1; m_vout = a_vh; m_rem = dur(a_th); newlvl = 1;
          end
        end
        1: begin
          if (stop) m_stopq = 1;
          m_rem--;
          if (m_rem == 0) begin
            m_mode = 2; m_vout = a_vl; m_rem = dur(a_tl); newlvl = 1;
          end
        end
        default: begin
          halt = m_stopq;
          if (stop) m_stopq = 1;
          m_rem--;
          if (m_rem == 0) begin
            if (halt) begin
              m_mode = 0; m_stopq = 0;
            end else begin
              if (m_pend) begin
                a_vh = s_vh; a_vl = s_vl; a_th = s_th; a_tl = s_tl; m_pend = 0;
              end
              m_mode = 1; m_vout = a_vh; m_rem = dur(a_th); newlvl = 1;
            end
          end
        end
      endcase
      if (cfg_load) begin
        s_vh = v_high; s_vl = v_low; s_th = t_high; s_tl = t_low; m_pend = 1;
      end
      if (newlvl) enq.push_back(cyc + PL);
    end
  end

  logic e_en, e_busy;
  always @(negedge clk) begin
    if (model_ok) begin
      e_en   = 1'b0;
      e_busy = (m_mode != 0);
      foreach (enq[k]) begin
        if (enq[k] == cyc) e_en = 1'b1;
        if (enq[k] >= cyc) e_busy = 1'b1;
      end
      check("model v_out", v_out, m_vout);
      check("model en", en, e_en);
      check("model busy", busy, e_busy);
      check("model phase", phase, m_mode == 1);
      check("model period_done", period_done, (m_mode == 2) && (m_rem == 1));
    end
  end

  logic [11:0] b_vout [1:12] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'h100, 12'h100, 12'hFFF,
                                 12'hFFF, 12'hFFF, 12'h100, 12'h100, 12'h100, 12'h100};
  logic [1:12] b_en    = 12'b0010_0101_0010;
  logic [1:12] b_pd    = 12'b0000_1000_0100;
  logic [1:12] b_phase = 12'b1110_0111_0000;
  logic [1:12] b_busy  = 12'b1111_1111_1110;
  logic [1:10] m_phase = 10'b1110_0100_10;
  logic [1:10] m_pd    = 10'b0000_1001_00;
  logic [1:6]  z_en    = 6'b001111;

  task automatic lit_idle(input string nm);
    check({nm, " v_out"}, v_out, 12'h000);
    check({nm, " en"}, en, 1'b0);
    check({nm, " busy"}, busy, 1'b0);
    check({nm, " phase"}, phase, 1'b0);
    check({nm, " period_done"}, period_done, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; cfg_load = 1'b0;
    v_high = '0; v_low = '0; t_high = '0; t_low = '0;
    @(negedge clk);
    @(negedge clk);
    lit_idle("reset");
    reset = 1'b0;
    @(negedge clk);

    // Basic waveform, then Stop during HIGH of the second period
    v_high = 12'hFFF; v_low = 12'h100; t_high = 16'd3; t_low = 16'd2; cfg_load = 1'b1;
    @(negedge clk); cfg_load = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = (i == 7);
      check("basic v_out", v_out, b_vout[i]);
      check("basic en", en, b_en[i]);
      check("basic period_done", period_done, b_pd[i]);
      check("basic phase", phase, b_phase[i]);
      check("basic busy", busy, b_busy[i]);
    end
    stop = 1'b0;

    // Mid-run reconfiguration: THigh=1 takes effect only from period 2
    @(negedge clk); start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start    = (i == 4);
      cfg_load = (i == 2);
      if (i == 2) t_high = 16'd1;
      check("midcfg phase", phase, m_phase[i]);
      check("midcfg period_done", period_done, m_pd[i]);
    end
    cfg_load = 1'b0; start = 1'b0;

    // Reset held two cycles mid-run
    reset = 1'b1;
    @(negedge clk);
    lit_idle("midreset");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("postreset en", en, 1'b0);
      check("postreset busy", busy, 1'b0);
    end

    // Zero durations; Start one cycle after CfgLoad so the copy and start coincide
    v_high = 12'hABC; v_low = 12'h123; t_high = 16'd0; t_low = 16'd0; cfg_load = 1'b1;
    @(negedge clk); cfg_load = 1'b0; start = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = (i == 4);
      if (i <= 6) begin
        check("zero v_out", v_out, (i % 2 == 1) ? 12'hABC : 12'h123);
        check("zero en", en, z_en[i]);
      end
    end
    stop = 1'b0;
    check("zero idle busy", busy, 1'b0);
    check("zero idle v_out", v_out, 12'h123);

    // Stop alone in IDLE is dropped; Start+Stop together stays IDLE
    stop = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("startstop busy", busy, 1'b0);
      check("startstop en", en, 1'b0);
      check("startstop phase", phase, 1'b0);
    end
    start = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 3) check("no stale stop phase", phase, 1'b1);
    end
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    for (int i = 0; i < 8; i++) @(negedge clk);
    check("final busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
